imm_extend_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational sign extender. Converts an INWIDTH-bit immediate into an OUTWIDTH-bit operand in one of four modes: sign, zero, upper/LUI, branch-offset. Sits between decode and the ALU operand mux. Uses a valid/ready handshake with a 2-entry output buffer (output register plus skid register), so that ALU stalls never drop or reorder immediates.

---
 rtl/imm_extend_pipe_if.sv | 25 ++
 rtl/imm_extend_pipe.sv | 132 +++++++++++++
 tb/tb_imm_extend_pipe.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: input channel (valid/ready/din/mode) and
// output channel (valid/ready/dout/dout_mode).
interface imm_extend_pipe_if #(
   parameter int unsigned INWIDTH  = 16,
   parameter int unsigned OUTWIDTH = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [INWIDTH-1:0]  din;
   logic [1:0]          mode;
   logic                out_valid;
   logic                out_ready;
   logic [OUTWIDTH-1:0] dout;
   logic [1:0]          dout_mode;

   modport master (
      output in_valid, din, mode, out_ready,
      input  in_ready, out_valid, dout, dout_mode
   );

   modport slave (
      input  in_valid, din, mode, out_ready,
      output in_ready, out_valid, dout, dout_mode
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/branch) with a 2-entry output buffer.
// Define IMM_EXTEND_CNT_EN to add the xfer_cnt output-transfer counter.
module imm_extend_pipe #(
   parameter int unsigned INWIDTH  = 16,
   parameter int unsigned OUTWIDTH = 32,
   parameter int unsigned BR_SHIFT = 2
) (
   input logic              clk,
   input logic              rst_n,
   imm_extend_pipe_if.slave bus
`ifdef IMM_EXTEND_CNT_EN
   ,
   output logic [15:0]      xfer_cnt
`endif
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e              state_q, state_d;
   logic                in_xfer, out_xfer;
   logic                load_out, load_skid, move_skid;
   logic [OUTWIDTH-1:0] ext;
   logic [OUTWIDTH-1:0] dout_q, skid_q;
   logic [1:0]          dout_mode_q, skid_mode_q;

   function automatic logic [OUTWIDTH-1:0] extend(logic [INWIDTH-1:0] d, logic [1:0] m);
      logic [OUTWIDTH-1:0] sext, zext, res;
      sext = {OUTWIDTH{d[INWIDTH-1]}};
      sext[INWIDTH-1:0] = d;
      zext = '0;
      zext[INWIDTH-1:0] = d;
      unique case (m)
         2'b00:   res = sext;
         2'b01:   res = zext;
         2'b10:   res = zext << (OUTWIDTH - INWIDTH);
         2'b11:   res = sext << BR_SHIFT;
         default: res = '0;
      endcase
      return res;
   endfunction

   assign ext      = extend(bus.din, bus.mode);
   // Readiness comes straight from registered state, never from out_ready.
   assign in_xfer  = bus.in_valid && (state_q != StFull);
   assign out_xfer = (state_q != StEmpty) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      unique case (state_q)
         StEmpty: begin
            if (in_xfer) begin
               load_out = 1'b1;
               state_d  = StOne;
            end
         end
         StOne: begin
            if (out_xfer && in_xfer) begin
               load_out = 1'b1;
            end else if (out_xfer) begin
               state_d = StEmpty;
            end else if (in_xfer) begin
               load_skid = 1'b1;
               state_d   = StFull;
            end
         end
         StFull: begin
            if (out_xfer) begin
               move_skid = 1'b1;
               state_d   = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q != StFull);
      bus.out_valid = (state_q != StEmpty);
      bus.dout      = dout_q;
      bus.dout_mode = dout_mode_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_q      <= '0;
         dout_mode_q <= '0;
         skid_q      <= '0;
         skid_mode_q <= '0;
      end else begin
         if (load_out) begin
            dout_q      <= ext;
            dout_mode_q <= bus.mode;
         end else if (move_skid) begin
            dout_q      <= skid_q;
            dout_mode_q <= skid_mode_q;
         end
         if (load_skid) begin
            skid_q      <= ext;
            skid_mode_q <= bus.mode;
         end
      end
   end

`ifdef IMM_EXTEND_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (out_xfer) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign xfer_cnt = cnt_q;
`endif

   out_valid_needs_input: assert property (@(posedge clk) disable iff (!rst_n)
      $rose(state_q != StEmpty) |-> $past(in_xfer));

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: FIFO-depth-2 reference model checked every
// cycle, plus directed literal checks and a second 4->8 instance.
module tb_imm_extend_pipe;
   localparam int unsigned IW = 16;
   localparam int unsigned OW = 32;
   localparam int unsigned BS = 2;

   typedef struct packed {
      logic [OW-1:0] d;
      logic [1:0]    m;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imm_extend_pipe_if #(.INWIDTH(IW), .OUTWIDTH(OW)) bus ();
   imm_extend_pipe_if #(.INWIDTH(4), .OUTWIDTH(8)) bus2 ();

`ifdef IMM_EXTEND_CNT_EN
   logic [15:0] xfer_cnt, xfer_cnt2;
`endif

   imm_extend_pipe #(.INWIDTH(IW), .OUTWIDTH(OW), .BR_SHIFT(BS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus)
`ifdef IMM_EXTEND_CNT_EN
      ,
      .xfer_cnt(xfer_cnt)
`endif
   );

   imm_extend_pipe #(.INWIDTH(4), .OUTWIDTH(8), .BR_SHIFT(2)) dut2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus2)
`ifdef IMM_EXTEND_CNT_EN
      ,
      .xfer_cnt(xfer_cnt2)
`endif
   );

   int   n_checks = 0;
   int   n_errors = 0;
   ent_t q[$];
   logic [OW-1:0] got[$];
   logic taken = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain signed/unsigned arithmetic on 64-bit values.
   function automatic logic [OW-1:0] ref_ext(input logic [IW-1:0] d, input logic [1:0] m);
      longint s, u;
      s = longint'($signed(d));
      u = longint'(d);
      case (m)
         2'd0:    return OW'(s);
         2'd1:    return OW'(u);
         2'd2:    return OW'(u * (longint'(1) << (OW - IW)));
         default: return OW'(s * (longint'(1) << BS));
      endcase
   endfunction

   // Compare against the model, then book the handshakes of the coming edge.
   always @(negedge clk) begin
      logic in_x, out_x;
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      if (bus.out_valid && q.size() > 0) begin
         check("dout", 64'(bus.dout), 64'(q[0].d));
         check("dout_mode", 64'(bus.dout_mode), 64'(q[0].m));
      end
      in_x  = rst_n && bus.in_valid && (q.size() < 2);
      out_x = rst_n && (q.size() > 0) && bus.out_ready;
      taken = in_x;
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_x) begin
            got.push_back(bus.dout);
            void'(q.pop_front());
         end
         if (in_x) q.push_back('{ref_ext(bus.din, bus.mode), bus.mode});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_check(input string name, input logic [IW-1:0] d, input logic [1:0] m,
                             input logic [OW-1:0] exp);
      check({"model ", name}, 64'(ref_ext(d, m)), 64'(exp));
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.din       = d;
      bus.mode      = m;
      step();
      bus.in_valid = 1'b0;
      check({name, " valid"}, 64'(bus.out_valid), 64'd1);
      check(name, 64'(bus.dout), 64'(exp));
      check({name, " mode"}, 64'(bus.dout_mode), 64'(m));
      step();
   endtask

   task automatic send2(input string name, input logic [3:0] d, input logic [7:0] exp);
      bus2.in_valid = 1'b1;
      bus2.din      = d;
      bus2.mode     = 2'b00;
      step();
      bus2.in_valid = 1'b0;
      check({name, " valid"}, 64'(bus2.out_valid), 64'd1);
      check(name, 64'(bus2.dout), 64'(exp));
      step();
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus2.in_valid = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.din        = '0;
      bus.mode       = 2'b00;
      bus.out_ready  = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.din       = '0;
      bus2.mode      = 2'b00;
      bus2.out_ready = 1'b1;
      step();
      step();
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst dout", 64'(bus.dout), 64'd0);
      check("rst dout_mode", 64'(bus.dout_mode), 64'd0);
      check("rst in_ready", 64'(bus.in_ready), 64'd1);
      rst_n = 1'b1;
      step();

      send_check("sign 8000", 16'h8000, 2'b00, 32'hFFFF_8000);
      send_check("zero 8000", 16'h8000, 2'b01, 32'h0000_8000);
      send_check("upper 1234", 16'h1234, 2'b10, 32'h1234_0000);
      send_check("branch FFFF", 16'hFFFF, 2'b11, 32'hFFFF_FFFC);
      send_check("branch 0003", 16'h0003, 2'b11, 32'h0000_000C);

      send2("i2 0011", 4'b0011, 8'b0000_0011);
      send2("i2 1000", 4'b1000, 8'b1111_1000);
      send2("i2 1101", 4'b1101, 8'b1111_1101);

      // Backpressure: A, B accepted, C held until the consumer drains.
      got.delete();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.mode      = 2'b00;
      bus.din       = 16'h0001;
      step();
      check("bp in_ready after A", 64'(bus.in_ready), 64'd1);
      bus.din = 16'h0002;
      step();
      check("bp in_ready after B", 64'(bus.in_ready), 64'd0);
      bus.din = 16'h0003;
      repeat (3) begin
         step();
         check("bp in_ready held", 64'(bus.in_ready), 64'd0);
         check("bp dout stable", 64'(bus.dout), 64'h1);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && got.size() < 3; i++) begin
         step();
         if (taken) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      check("bp count", 64'(got.size()), 64'd3);
      if (got.size() >= 3) begin
         check("bp out A", 64'(got[0]), 64'h1);
         check("bp out B", 64'(got[1]), 64'h2);
         check("bp out C", 64'(got[2]), 64'h3);
      end

      // Back-to-back streaming, 8 results.
      step();
      got.delete();
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.din  = 16'($urandom);
         bus.mode = 2'($urandom);
         step();
         check("stream in_ready", 64'(bus.in_ready), 64'd1);
      end
      bus.in_valid = 1'b0;
      step();
      step();
      check("stream count", 64'(got.size()), 64'd8);

      // Randomised traffic; producer holds an offer until it is accepted.
      bus.in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!bus.in_valid || taken) begin
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.din      = 16'($urandom);
            bus.mode     = 2'($urandom);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) step();
      check("random drained", 64'(q.size()), 64'd0);

      // Reset while FULL.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.din       = 16'h00AA;
      step();
      bus.din = 16'h00BB;
      step();
      check("full in_ready", 64'(bus.in_ready), 64'd0);
      do_reset();
      check("rst2 out_valid", 64'(bus.out_valid), 64'd0);
      check("rst2 dout", 64'(bus.dout), 64'd0);
      check("rst2 in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      repeat (3) begin
         step();
         check("rst2 no stale", 64'(bus.out_valid), 64'd0);
      end

`ifdef IMM_EXTEND_CNT_EN
      do_reset();
      check("cnt reset", 64'(xfer_cnt), 64'd0);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.din       = 16'h0005;
      bus.mode      = 2'b01;
      repeat (3) step();
      bus.in_valid = 1'b0;
      step();
      check("cnt 3", 64'(xfer_cnt), 64'd3);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 70000 && xfer_cnt != 16'hFFFF; i++) step();
      check("cnt FFFF", 64'(xfer_cnt), 64'hFFFF);
      step();
      check("cnt wrap", 64'(xfer_cnt), 64'd0);
      bus.in_valid = 1'b0;
      repeat (3) step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
